// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings, default timing parameters and constants for the hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam int DEFAULT_DIV_CYCLES  = 8;
  localparam int DEFAULT_MEM_TIMEOUT = 64;

  localparam logic [4:0] REG_ZERO = 5'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// hazard_cycle_counter: loadable down-counter that saturates at zero and flags it.
module hazard_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; ctrl_state exposes the FSM for tracing.
// Optional HAZARD_TIMEOUT_EN adds a data-memory timeout with a mem_err pulse.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
`ifdef HAZARD_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
`endif
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_re1,
  input  logic       ID_re2,
  input  logic [4:0] EX_wr,
  input  logic       EX_isLoad,
  input  logic       EX_isDiv,
  input  logic       risk_Control,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output logic       stall_PC,
  output logic       stall_IF_ID,
  output logic       stall_ID_EX,
  output logic       stall_EX_MEM,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       flush_EX_MEM,
  output logic       flush_MEM_WB,
  output logic       div_done,
`ifdef HAZARD_TIMEOUT_EN
  output logic       mem_err,
`endif
  output logic [1:0] ctrl_state
);

  localparam int              DIV_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_CYCLES - 1);

  ctrl_state_t state, next_state;

  logic memw, lu;
  logic div_load, div_dec, div_zero;

  assign memw = dmem_req & ~dmem_ack;
  assign lu   = EX_isLoad & (EX_wr != REG_ZERO) &
                ((ID_re1 & (ID_rs1 == EX_wr)) | (ID_re2 & (ID_rs2 == EX_wr)));

  hazard_cycle_counter #(.W(DIV_W)) u_div_cnt (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .load     (div_load),
    .load_val (DIV_LOAD),
    .dec      (div_dec),
    .zero     (div_zero)
  );

`ifdef HAZARD_TIMEOUT_EN
  localparam int              TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(MEM_TIMEOUT - 1);

  logic to_load, to_dec, to_zero;

  hazard_cycle_counter #(.W(TO_W)) u_to_cnt (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .dec      (to_dec),
    .zero     (to_zero)
  );
`endif

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state <= RUN;
    else         state <= next_state;
  end

  always_comb begin
    next_state   = state;
    div_load     = 1'b0;
    div_dec      = 1'b0;
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    flush_MEM_WB = 1'b0;
    div_done     = 1'b0;
`ifdef HAZARD_TIMEOUT_EN
    to_load      = 1'b0;
    to_dec       = 1'b0;
    mem_err      = 1'b0;
`endif
    if (cpu_rst) begin
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (memw) begin
            {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 4'hf;
            flush_MEM_WB = 1'b1;
            next_state   = MEM_WAIT;
`ifdef HAZARD_TIMEOUT_EN
            to_load      = 1'b1;
`endif
          end else if (EX_isDiv) begin
            {stall_PC, stall_IF_ID, stall_ID_EX} = 3'b111;
            flush_EX_MEM = 1'b1;
            div_load     = 1'b1;
            next_state   = DIV_WAIT;
          end else if (risk_Control) begin
            // Wrong-path ID instruction: a load-use hit there is meaningless.
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (lu) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (!div_zero) begin
            {stall_PC, stall_IF_ID, stall_ID_EX} = 3'b111;
            flush_EX_MEM = 1'b1;
            div_dec      = 1'b1;
          end else begin
            div_done   = 1'b1;
            next_state = RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            next_state = RUN;
`ifdef HAZARD_TIMEOUT_EN
          end else if (to_zero) begin
            // Abort: drop the stuck access and let the pipeline move again.
            flush_EX_MEM = 1'b1;
            mem_err      = 1'b1;
            next_state   = RUN;
`endif
          end else begin
            {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 4'hf;
            flush_MEM_WB = 1'b1;
`ifdef HAZARD_TIMEOUT_EN
            to_dec       = 1'b1;
`endif
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign ctrl_state = cpu_rst ? 2'd0 : state;

endmodule
